// File: rtl/fifo_sink_mc_if.sv
// fifo_sink_mc_if: control, FIFO-side and memory-side signals of the multi-channel FIFO sink
// Ports (slave = sink view):
//   in : start_i, stop_i, nop_i, mode_i, ch_en_i, ilen_i, empty_i, data_i
//   out: rd_en_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, wrap_o
interface fifo_sink_mc_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 7,
    parameter int NUM_CH     = 4
);
    localparam int CH_BITS = $clog2(NUM_CH);

    logic                             start_i;
    logic                             stop_i;
    logic                             nop_i;
    logic                             mode_i;
    logic [NUM_CH-1:0]                ch_en_i;
    logic [ADDR_WIDTH:0]              ilen_i;
    logic [NUM_CH-1:0]                empty_i;
    logic [NUM_CH*DATA_WIDTH-1:0]     data_i;
    logic [NUM_CH-1:0]                rd_en_o;
    logic                             wr_en_o;
    logic [CH_BITS+ADDR_WIDTH-1:0]    wr_addr_o;
    logic [DATA_WIDTH-1:0]            wr_data_o;
    logic                             busy_o;
    logic                             done_o;
    logic [NUM_CH-1:0]                wrap_o;

    modport slave (
        input  start_i, stop_i, nop_i, mode_i, ch_en_i, ilen_i, empty_i, data_i,
        output rd_en_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, wrap_o
    );

    modport master (
        output start_i, stop_i, nop_i, mode_i, ch_en_i, ilen_i, empty_i, data_i,
        input  rd_en_o, wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, wrap_o
    );
endinterface

// File: rtl/fifo_sink_mc.sv
// fifo_sink_mc: drains NUM_CH sample FIFOs round-robin into a banked result memory
// Ports:
//   clk  : rising-edge clock
//   rstn : asynchronous active-low reset
//   bus  : fifo_sink_mc_if.slave -- start/stop/nop/mode/mask/length controls, FIFO empty flags
//          and read data in; one-hot FIFO read strobe, memory write strobe/address/data,
//          busy, done pulse and per-channel wrap pulses out
module fifo_sink_mc #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 7,
    parameter int NUM_CH     = 4
) (
    input logic           clk,
    input logic           rstn,
    fifo_sink_mc_if.slave bus
);
    localparam int                 CH_BITS = $clog2(NUM_CH);
    localparam logic [CH_BITS:0]   NCH     = (CH_BITS+1)'(NUM_CH);
    localparam logic [CH_BITS-1:0] LAST    = CH_BITS'(NUM_CH-1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t                         r_state;
    state_t                         w_state_nxt;
    logic                           r_mode;
    logic [NUM_CH-1:0]              r_mask;
    logic [ADDR_WIDTH:0]            r_ilen;
    logic [NUM_CH-1:0][ADDR_WIDTH:0] r_cnt;
    logic [CH_BITS-1:0]             r_ptr;
    logic                           r_wr_en;
    logic [CH_BITS-1:0]             r_wr_ch;
    logic [ADDR_WIDTH-1:0]          r_wr_idx;
    logic [NUM_CH-1:0]              r_wrap;

    logic [NUM_CH-1:0]              w_elig;
    logic                           w_found;
    logic [CH_BITS-1:0]             w_gnt;
    logic [CH_BITS:0]               w_k;
    logic                           w_stop;
    logic                           w_issue;
    logic                           w_all_done;
    logic [NUM_CH-1:0]              w_rd;
    logic [DATA_WIDTH-1:0]          w_wr_data;

    // Arbitration, read strobe and completion; completion looks at the counters as they
    // will be after this cycle's read, so the last write lands in DRAIN.
    always_comb begin
        w_elig     = '0;
        w_found    = 1'b0;
        w_gnt      = '0;
        w_k        = '0;
        w_rd       = '0;
        w_all_done = 1'b1;
        for (int c = 0; c < NUM_CH; c++)
            w_elig[c] = r_mask[c] & ~bus.empty_i[c] & (r_mode | (r_cnt[c] < r_ilen));
        for (int i = 0; i < NUM_CH; i++) begin
            w_k = {1'b0, r_ptr} + (CH_BITS+1)'(i);
            w_k = (w_k >= NCH) ? w_k - NCH : w_k;
            if (!w_found && w_elig[w_k[CH_BITS-1:0]]) begin
                w_found = 1'b1;
                w_gnt   = w_k[CH_BITS-1:0];
            end
        end
        // Circular mode with nothing to wrap over finishes immediately, like one-shot.
        w_stop  = r_mode & (bus.stop_i | (r_ilen == '0) | (r_mask == '0));
        w_issue = (r_state == RUN) & ~bus.nop_i & ~w_stop & w_found;
        w_rd[w_gnt] = w_issue;
        for (int c = 0; c < NUM_CH; c++)
            if (r_mask[c] && ((r_cnt[c] + (ADDR_WIDTH+1)'(w_issue && w_gnt == CH_BITS'(c))) != r_ilen))
                w_all_done = 1'b0;
        w_state_nxt = (r_state == IDLE)  ? (bus.start_i ? RUN : IDLE) :
                      (r_state == RUN)   ? ((r_mode ? w_stop : w_all_done) ? DRAIN : RUN) :
                      (r_state == DRAIN) ? DONE : IDLE;
    end

    // Write data is taken straight from the FIFO output the cycle after the read.
    always_comb begin
        w_wr_data = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (r_wr_en && r_wr_ch == CH_BITS'(c))
                w_wr_data = bus.data_i[c*DATA_WIDTH +: DATA_WIDTH];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_mode   <= 1'b0;
            r_mask   <= '0;
            r_ilen   <= '0;
            r_cnt    <= '0;
            r_ptr    <= '0;
            r_wr_en  <= 1'b0;
            r_wr_ch  <= '0;
            r_wr_idx <= '0;
            r_wrap   <= '0;
        end else begin
            r_wr_en <= w_issue;
            r_wrap  <= '0;
            if (r_state == IDLE && bus.start_i) begin
                r_mode <= bus.mode_i;
                r_mask <= bus.ch_en_i;
                r_ilen <= bus.ilen_i;
                r_cnt  <= '0;
                r_ptr  <= '0;
            end
            if (w_issue) begin
                r_wr_ch  <= w_gnt;
                r_wr_idx <= r_cnt[w_gnt][ADDR_WIDTH-1:0];
                r_ptr    <= (w_gnt == LAST) ? '0 : w_gnt + 1'b1;
                if (r_mode && r_cnt[w_gnt] == r_ilen - 1'b1) begin
                    r_cnt[w_gnt]  <= '0;
                    r_wrap[w_gnt] <= 1'b1;
                end else begin
                    r_cnt[w_gnt] <= r_cnt[w_gnt] + 1'b1;
                end
            end
        end
    end

    assign bus.rd_en_o   = w_rd;
    assign bus.wr_en_o   = r_wr_en;
    assign bus.wr_addr_o = {r_wr_ch, r_wr_idx};
    assign bus.wr_data_o = w_wr_data;
    assign bus.busy_o    = (r_state == RUN) || (r_state == DRAIN);
    assign bus.done_o    = (r_state == DONE);
    assign bus.wrap_o    = r_wrap;
endmodule
